victory_overlay: RTL and testbench

Downstream consumer of the 16x16 victory sprite ROM. On a win event it displays the sprite, scaled and positioned on screen, for a fixed number of frames. Per pixel it drives the ROM read address from `DrawX`/`DrawY`, absorbs the ROM's one-cycle registered read, maps the 4-bit palette index to 24-bit RGB, and flags transparency. It feeds the colour mapper's top-priority overlay layer.

---
 rtl/victory_overlay_if.sv | 26 ++
 rtl/victory_overlay.sv | 128 ++++++++++++
 tb/tb_victory_overlay.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/victory_overlay_if.sv
// Pixel/ROM/control bundle between the victory overlay and its neighbours.
// The master drives the win/frame events, pixel coordinates and ROM data; the slave is the overlay.
interface victory_overlay_if;
  logic       win;
  logic       frame_tick;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [8:0] read_address;
  logic [3:0] rom_data;
  logic       sprite_on;
  logic [7:0] Red;
  logic [7:0] Green;
  logic [7:0] Blue;
  logic       active;
  logic       done;

  modport master (
    output win, frame_tick, DrawX, DrawY, rom_data,
    input  read_address, sprite_on, Red, Green, Blue, active, done
  );

  modport slave (
    input  win, frame_tick, DrawX, DrawY, rom_data,
    output read_address, sprite_on, Red, Green, Blue, active, done
  );
endinterface

// File: rtl/victory_overlay.sv
// Victory sprite overlay: timed SHOW window, scaled box test, 3-cycle pixel pipeline and palette.
// Optional blinking during SHOW is enabled by defining VICTORY_BLINK_EN.
module victory_overlay #(
  parameter int unsigned POS_X        = 288,
  parameter int unsigned POS_Y        = 208,
  parameter int unsigned SCALE_LOG2   = 2,
  parameter int unsigned HOLD_FRAMES  = 120,
  parameter int unsigned BLINK_FRAMES = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  victory_overlay_if.slave bus
);

  localparam int unsigned BOX   = 16 << SCALE_LOG2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CRD_W = 11;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t             state;
  logic [CNT_W-1:0]   frame_cnt;
  logic               phase;
  logic               vis_d1;
  logic               vis_d2;
  logic [CRD_W-1:0]   dx;
  logic [CRD_W-1:0]   dy;
  logic               in_box;
  logic               vis;
  logic               opaque;
  logic [8:0]         addr;

`ifdef VICTORY_BLINK_EN
  logic [CNT_W-1:0]   blink_cnt;
`else
  assign phase = 1'b1;
`endif

  function automatic logic [23:0] palette(input logic [3:0] idx);
    case (idx)
      4'd0:    palette = 24'h000000;
      4'd1:    palette = 24'hFFFFFF;
      4'd2:    palette = 24'h000000;
      4'd3:    palette = 24'hFFD700;
      4'd4:    palette = 24'hFF0000;
      4'd5:    palette = 24'h00FF00;
      4'd6:    palette = 24'h0000FF;
      default: palette = 24'h808080;
    endcase
  endfunction

  // Stage 0: signed box offsets; a set sign bit means left of / above the box.
  always_comb begin
    dx     = {1'b0, bus.DrawX} - CRD_W'(POS_X);
    dy     = {1'b0, bus.DrawY} - CRD_W'(POS_Y);
    in_box = !dx[CRD_W-1] && !dy[CRD_W-1] && (dx < CRD_W'(BOX)) && (dy < CRD_W'(BOX));
    addr   = {1'b0, dy[SCALE_LOG2+3 -: 4], dx[SCALE_LOG2+3 -: 4]};
    vis    = bus.active & in_box & phase;
    opaque = vis_d2 & (bus.rom_data != 4'd0);
  end

  // Show-window FSM with frame counter; done pulses on the exit transition only.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      bus.active <= 1'b0;
      bus.done   <= 1'b0;
`ifdef VICTORY_BLINK_EN
      phase      <= 1'b1;
      blink_cnt  <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.win) begin
            state      <= SHOW;
            frame_cnt  <= '0;
            bus.active <= 1'b1;
`ifdef VICTORY_BLINK_EN
            phase      <= 1'b1;
            blink_cnt  <= '0;
`endif
          end
        end
        SHOW: begin
          if (bus.frame_tick) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
            if (frame_cnt == CNT_W'(HOLD_FRAMES - 1)) begin
              state      <= IDLE;
              bus.active <= 1'b0;
              bus.done   <= 1'b1;
            end
`ifdef VICTORY_BLINK_EN
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
              blink_cnt <= '0;
              phase     <= ~phase;
            end else begin
              blink_cnt <= blink_cnt + CNT_W'(1);
            end
`endif
          end
        end
      endcase
    end
  end

  // Pixel pipeline: address/vis, ROM read slot, colour output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.read_address <= '0;
      vis_d1           <= 1'b0;
      vis_d2           <= 1'b0;
      bus.sprite_on    <= 1'b0;
      bus.Red          <= '0;
      bus.Green        <= '0;
      bus.Blue         <= '0;
    end else begin
      bus.read_address <= (bus.active & in_box) ? addr : '0;
      vis_d1           <= vis;
      vis_d2           <= vis_d1;
      bus.sprite_on    <= opaque;
      {bus.Red, bus.Green, bus.Blue} <= opaque ? palette(bus.rom_data) : 24'h000000;
    end
  end

endmodule

// File: tb/tb_victory_overlay.sv
// Self-checking bench for victory_overlay: randomized pixels against a frame/pixel-level model.
module tb_victory_overlay;

  localparam int HOLD  = 120;
  localparam int BLINK = 15;
  localparam int PX    = 288;
  localparam int PY    = 208;
  localparam int BOX   = 64;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  victory_overlay_if bus ();

  victory_overlay dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Registered sprite ROM model
  logic [3:0] rom [512];
  always @(posedge Clk) bus.rom_data <= rom[bus.read_address];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_active;
  bit          m_done;
  int          m_frames;
  logic        p1_on, p2_on, exp_on;
  logic [23:0] p1_rgb, p2_rgb, exp_rgb;
  logic [8:0]  exp_addr;

  function automatic logic [23:0] color(input int idx);
    case (idx)
      0: return 24'h000000;
      1: return 24'hFFFFFF;
      2: return 24'h000000;
      3: return 24'hFFD700;
      4: return 24'hFF0000;
      5: return 24'h00FF00;
      6: return 24'h0000FF;
      default: return 24'h808080;
    endcase
  endfunction

  function automatic bit inbox(input int x, input int y);
    return x >= PX && x < PX + BOX && y >= PY && y < PY + BOX;
  endfunction

  function automatic int addr_of(input int x, input int y);
    return ((y - PY) / (BOX / 16)) * 16 + (x - PX) / (BOX / 16);
  endfunction

  function automatic bit phase_vis(input int f);
`ifdef VICTORY_BLINK_EN
    return ((f / BLINK) % 2) == 0;
`else
    return f >= 0;
`endif
  endfunction

  // Drive one pixel cycle, advance the model across the clock edge, land #1 after it.
  task automatic cycle(input bit w, input bit t, input int x, input int y);
    bit          on_now;
    logic [23:0] c;
    int          a;
    bus.win        = w;
    bus.frame_tick = t;
    bus.DrawX      = 10'(x);
    bus.DrawY      = 10'(y);
    a      = (m_active && inbox(x, y)) ? addr_of(x, y) : 0;
    on_now = m_active && inbox(x, y) && phase_vis(m_frames) && (rom[a] != 4'd0);
    c      = on_now ? color(int'(rom[a])) : 24'h0;
    @(posedge Clk);
    if (Reset) begin
      m_active = 0; m_done = 0; m_frames = 0;
      p1_on = 0; p2_on = 0; exp_on = 0;
      p1_rgb = 0; p2_rgb = 0; exp_rgb = 0; exp_addr = 0;
    end else begin
      exp_on = p2_on;  exp_rgb = p2_rgb;
      p2_on  = p1_on;  p2_rgb  = p1_rgb;
      p1_on  = on_now; p1_rgb  = c;
      exp_addr = 9'(a);
      m_done = 0;
      if (!m_active) begin
        if (w) begin m_active = 1; m_frames = 0; end
      end else if (t) begin
        m_frames++;
        if (m_frames == HOLD) begin m_active = 0; m_done = 1; end
      end
    end
    #1;
  endtask

  task automatic end_show();
    for (int i = 0; i < 300 && m_active; i++) cycle(1'b0, 1'b1, 0, 0);
    repeat (3) cycle(1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 300, 220);
    n_cmp++;
    if ({bus.sprite_on, bus.Red, bus.Green, bus.Blue, bus.read_address, bus.active, bus.done} !== 36'h0) begin
      n_bad++;
      $display("FAIL reset_outs: got on=%b rgb=%h addr=%h act=%b done=%b want all 0",
               bus.sprite_on, {bus.Red, bus.Green, bus.Blue}, bus.read_address, bus.active, bus.done);
    end
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 300, 220);
      n_cmp++;
      if ({bus.sprite_on, bus.Red, bus.Green, bus.Blue, bus.read_address, bus.active, bus.done} !== 36'h0) begin
        n_bad++;
        $display("FAIL idle_outs: got on=%b rgb=%h addr=%h act=%b done=%b want all 0",
                 bus.sprite_on, {bus.Red, bus.Green, bus.Blue}, bus.read_address, bus.active, bus.done);
      end
    end
  endtask

  task automatic test_pixel();
    cycle(1'b1, 1'b0, 0, 0);
    n_cmp++;
    if (bus.active !== 1'b1) begin
      n_bad++; $display("FAIL win_active: got %b want 1", bus.active);
    end
    cycle(1'b0, 1'b0, PX, PY);
    n_cmp++;
    if (bus.read_address !== 9'h000) begin
      n_bad++; $display("FAIL first_addr: got %h want 000", bus.read_address);
    end
    cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 0, 0);
    n_cmp++;
    if ({bus.sprite_on, bus.Red, bus.Green, bus.Blue} !== {1'b1, 24'hFFD700}) begin
      n_bad++;
      $display("FAIL first_pix: got on=%b rgb=%h want on=1 rgb=ffd700",
               bus.sprite_on, {bus.Red, bus.Green, bus.Blue});
    end
  endtask

  task automatic test_edges();
    int xs[5] = '{351, 292, 352, 287, 288};
    int ys[5] = '{271, 208, 208, 208, 272};
    int x, y;
    for (int i = 0; i < 48; i++) begin
      if (i < 5) begin x = xs[i]; y = ys[i]; end
      else if (i < 45) begin x = int'($urandom_range(270, 370)); y = int'($urandom_range(190, 290)); end
      else begin x = 0; y = 0; end
      cycle(1'b0, 1'b0, x, y);
      if (i == 0) begin
        n_cmp++;
        if (bus.read_address !== 9'h0FF) begin
          n_bad++; $display("FAIL corner_addr: got %h want 0ff", bus.read_address);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (bus.read_address !== 9'h001) begin
          n_bad++; $display("FAIL texel1_addr: got %h want 001", bus.read_address);
        end
      end
      n_cmp++;
      if ({bus.sprite_on, bus.Red, bus.Green, bus.Blue, bus.read_address} !== {exp_on, exp_rgb, exp_addr}) begin
        n_bad++;
        $display("FAIL edges_pix: got on=%b rgb=%h addr=%h want on=%b rgb=%h addr=%h",
                 bus.sprite_on, {bus.Red, bus.Green, bus.Blue}, bus.read_address, exp_on, exp_rgb, exp_addr);
      end
    end
  endtask

  task automatic test_hold();
    int dp = 0;
    cycle(1'b1, 1'b1, PX, PY);
    for (int k = 1; k <= HOLD + 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        cycle(k == 50 && j == 1, j == 0 && k <= HOLD,
              int'($urandom_range(280, 360)), int'($urandom_range(200, 280)));
        if (bus.done === 1'b1) dp++;
        n_cmp++;
        if ({bus.active, bus.done} !== {m_active, m_done}) begin
          n_bad++;
          $display("FAIL hold_ctl k=%0d: got act=%b done=%b want act=%b done=%b",
                   k, bus.active, bus.done, m_active, m_done);
        end
        n_cmp++;
        if ({bus.sprite_on, bus.Red, bus.Green, bus.Blue, bus.read_address} !== {exp_on, exp_rgb, exp_addr}) begin
          n_bad++;
          $display("FAIL hold_pix k=%0d: got on=%b rgb=%h addr=%h want on=%b rgb=%h addr=%h", k,
                   bus.sprite_on, {bus.Red, bus.Green, bus.Blue}, bus.read_address, exp_on, exp_rgb, exp_addr);
        end
      end
    end
    n_cmp++;
    if (dp != 1) begin
      n_bad++; $display("FAIL hold_done_count: got %0d want 1", dp);
    end
  endtask

  task automatic test_blink();
    cycle(1'b1, 1'b0, 0, 0);
    for (int f = 0; f < HOLD; f++) begin
      for (int j = 0; j < 5; j++) begin
        cycle(1'b0, 1'b0, PX, PY);
        n_cmp++;
        if ({bus.sprite_on, bus.Red, bus.Green, bus.Blue} !== {exp_on, exp_rgb}) begin
          n_bad++;
          $display("FAIL blink_pix f=%0d: got on=%b rgb=%h want on=%b rgb=%h",
                   f, bus.sprite_on, {bus.Red, bus.Green, bus.Blue}, exp_on, exp_rgb);
        end
      end
      n_cmp++;
      if (bus.sprite_on !== logic'(phase_vis(f))) begin
        n_bad++; $display("FAIL blink_phase f=%0d: got %b want %b", f, bus.sprite_on, phase_vis(f));
      end
      cycle(1'b0, 1'b1, PX, PY);
    end
    end_show();
  endtask

  task automatic test_reset_mid();
    int dp = 0;
    cycle(1'b1, 1'b0, PX, PY);
    for (int k = 1; k <= 60; k++) begin
      cycle(1'b0, 1'b1, PX, PY);
      cycle(1'b0, 1'b0, PX, PY);
      n_cmp++;
      if ({bus.active, bus.done, bus.sprite_on, bus.Red, bus.Green, bus.Blue} !== {m_active, m_done, exp_on, exp_rgb}) begin
        n_bad++;
        $display("FAIL pre_reset k=%0d: got act=%b done=%b on=%b rgb=%h want act=%b done=%b on=%b rgb=%h", k,
                 bus.active, bus.done, bus.sprite_on, {bus.Red, bus.Green, bus.Blue}, m_active, m_done, exp_on, exp_rgb);
      end
    end
    Reset = 1'b1;
    cycle(1'b0, 1'b0, PX, PY);
    n_cmp++;
    if ({bus.sprite_on, bus.Red, bus.Green, bus.Blue, bus.read_address, bus.active, bus.done} !== 36'h0) begin
      n_bad++;
      $display("FAIL mid_reset: got on=%b rgb=%h addr=%h act=%b done=%b want all 0",
               bus.sprite_on, {bus.Red, bus.Green, bus.Blue}, bus.read_address, bus.active, bus.done);
    end
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, PX, PY);
      n_cmp++;
      if ({bus.active, bus.done, bus.sprite_on} !== 3'b000) begin
        n_bad++;
        $display("FAIL post_reset: got act=%b done=%b on=%b want 000", bus.active, bus.done, bus.sprite_on);
      end
    end
    cycle(1'b1, 1'b0, PX, PY);
    for (int k = 1; k <= HOLD + 1; k++) begin
      for (int j = 0; j < 2; j++) begin
        cycle(1'b0, j == 0 && k <= HOLD, PX, PY);
        if (bus.done === 1'b1) dp++;
        n_cmp++;
        if ({bus.active, bus.done} !== {m_active, m_done}) begin
          n_bad++;
          $display("FAIL rerun_ctl k=%0d: got act=%b done=%b want act=%b done=%b",
                   k, bus.active, bus.done, m_active, m_done);
        end
      end
    end
    n_cmp++;
    if (dp != 1) begin
      n_bad++; $display("FAIL rerun_done_count: got %0d want 1", dp);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[0] = 4'd3;
    rom[1] = 4'd0;
    Reset = 1'b1;
    test_reset();
    test_pixel();
    test_edges();
    end_show();
    test_hold();
    test_blink();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
